dealign: RTL

DEALIGN -- requirements
Module: dealign

---
 rtl/dealign.sv | 91 +++++++++
 1 files changed

// File: rtl/dealign.sv
// dealign: 21-bit to 16-bit LSB-first gearbox (inverse of the 16-to-21 packer).
// Optional define DEALIGN_FLUSH_EN adds a flush input that drains and zero-pads residual bits.
`default_nettype none

module dealign (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  input  logic [20:0] in_data,
  output logic        in_ready,
  output logic        out_valid,
  output logic [15:0] out_data,
  input  logic        out_ready,
  output logic [5:0]  fill
`ifdef DEALIGN_FLUSH_EN
  ,
  input  logic        flush
`endif
);

  localparam logic [5:0] C_WORD_W  = 6'd16;
  localparam logic [5:0] C_FRAME_W = 6'd21;
  localparam logic [5:0] C_MAX_RES = 6'd15;

  logic [35:0] buf_q, buf_d;
  logic [5:0]  count_q, count_d;
  logic        pend;

  logic        out_fire;
  logic        accept;
  logic [5:0]  pop;
  logic [5:0]  remain;
  logic [35:0] shifted;

`ifdef DEALIGN_FLUSH_EN
  logic flush_pend_q, flush_pend_d;
  assign pend = flush_pend_q;
`else
  assign pend = 1'b0;
`endif

  assign out_valid = (count_q >= C_WORD_W) | (pend & (count_q != 6'd0));
  assign out_data  = buf_q[15:0];
  assign fill      = count_q;

  assign out_fire  = out_valid & out_ready;
  assign pop       = out_fire ? ((count_q >= C_WORD_W) ? C_WORD_W : count_q) : 6'd0;
  assign remain    = count_q - pop;
  assign in_ready  = ~pend & (remain <= C_MAX_RES);
  assign accept    = in_valid & in_ready;

  // A partial (flushed) word has no bits above 15, so the 16-bit shift still empties it.
  assign shifted   = out_fire ? (buf_q >> 16) : buf_q;

  always_comb begin
    buf_d   = shifted;
    count_d = remain;
    if (accept) begin
      buf_d   = shifted | ({15'd0, in_data} << remain);
      count_d = remain + C_FRAME_W;
    end
  end

`ifdef DEALIGN_FLUSH_EN
  // Clearing on count_d == 0 also covers a flush that arrives on the very fire that empties the buffer.
  always_comb begin
    flush_pend_d = (flush_pend_q | (flush & (count_q != 6'd0))) & (count_d != 6'd0);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      flush_pend_q <= 1'b0;
    end else begin
      flush_pend_q <= flush_pend_d;
    end
  end
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      buf_q   <= 36'd0;
      count_q <= 6'd0;
    end else begin
      buf_q   <= buf_d;
      count_q <= count_d;
    end
  end

endmodule

`default_nettype wire
